// File: rtl/axi_mem_responder.sv
// AXI4 subordinate: one INCR burst at a time onto a fixed-latency 64-bit memory, with a single exclusive reservation.
// Latency: first R beat 3 cycles after AR, 3 cycles per read beat; W taken one beat per cycle from the cycle after AW.
// Backpressure: r_valid/b_valid hold with stable payload until ready; AR/AW/W refused outside their serving states.
package ariane_axi;
    localparam int unsigned IdWidth = 4;
    typedef logic [IdWidth-1:0] id_t;

    typedef struct packed {
        id_t         id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
    } aw_chan_t;

    typedef struct packed {
        id_t         id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t         id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_mem_responder #(
    parameter int unsigned AxiNumWords = 4,
    parameter int unsigned AxiIdWidth  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [63:0]       mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_be_o,
    input  logic [63:0]       mem_rdata_i
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t                r_state;
    logic [63:0]           r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [AxiIdWidth-1:0] r_id;
    logic                  r_lock;
    logic                  r_err;
    logic                  r_excl_ok;
    logic                  r_bad_last;
    logic                  r_last_wr;
    logic [8:0]            r_cnt;
    logic [63:0]           r_rdata;
    logic                  r_res_vld;
    logic [60:0]           r_res_addr;
    logic [AxiIdWidth-1:0] r_res_id;

    logic        w_sel_rd;
    logic        w_sel_wr;
    logic        w_ar_err;
    logic        w_aw_err;
    logic        w_aw_excl_ok;
    logic        w_suppress;
    logic        w_res_hit;
    logic        w_last_beat;
    logic [63:0] w_addr_nxt;
    logic        w_unused;

    // On a tie, serve whichever channel was not served last.
    assign w_sel_rd = axi_req_i.ar_valid && (!axi_req_i.aw_valid || r_last_wr);
    assign w_sel_wr = axi_req_i.aw_valid && !w_sel_rd;

    assign w_ar_err = (32'(axi_req_i.ar.len) >= AxiNumWords) || (axi_req_i.ar.size > 3'd3);
    assign w_aw_err = (32'(axi_req_i.aw.len) >= AxiNumWords) || (axi_req_i.aw.size > 3'd3)
                   || (axi_req_i.aw.atop != 6'd0);
    assign w_aw_excl_ok = r_res_vld && (r_res_addr == axi_req_i.aw.addr[63:3])
                       && (r_res_id == axi_req_i.aw.id);

    assign w_suppress  = r_err || (r_cnt > {1'b0, r_len}) || (r_lock && !r_excl_ok);
    assign w_res_hit   = r_res_vld && (r_addr[63:3] == r_res_addr);
    assign w_last_beat = (r_cnt == {1'b0, r_len});
    assign w_addr_nxt  = r_addr + (64'd1 << r_size);

    assign w_unused = ^{axi_req_i.aw.burst, axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                        axi_req_i.aw.region, axi_req_i.ar.burst, axi_req_i.ar.cache, axi_req_i.ar.prot,
                        axi_req_i.ar.qos, axi_req_i.ar.region};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_id       <= '0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_excl_ok  <= 1'b0;
            r_bad_last <= 1'b0;
            r_last_wr  <= 1'b1;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_res_vld  <= 1'b0;
            r_res_addr <= '0;
            r_res_id   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_sel_rd) begin
                        r_addr    <= axi_req_i.ar.addr;
                        r_len     <= axi_req_i.ar.len;
                        r_size    <= axi_req_i.ar.size;
                        r_id      <= axi_req_i.ar.id;
                        r_lock    <= axi_req_i.ar.lock;
                        r_err     <= w_ar_err;
                        r_cnt     <= '0;
                        r_last_wr <= 1'b0;
                        if (axi_req_i.ar.lock) begin
                            r_res_vld  <= 1'b1;
                            r_res_addr <= axi_req_i.ar.addr[63:3];
                            r_res_id   <= axi_req_i.ar.id;
                        end
                        r_state <= RD_REQ;
                    end else if (w_sel_wr) begin
                        r_addr     <= axi_req_i.aw.addr;
                        r_len      <= axi_req_i.aw.len;
                        r_size     <= axi_req_i.aw.size;
                        r_id       <= axi_req_i.aw.id;
                        r_lock     <= axi_req_i.aw.lock;
                        r_err      <= w_aw_err;
                        r_excl_ok  <= w_aw_excl_ok;
                        r_bad_last <= 1'b0;
                        r_cnt      <= '0;
                        r_last_wr  <= 1'b1;
                        r_state    <= WR_DATA;
                    end
                end
                RD_REQ:  r_state <= RD_WAIT;
                RD_WAIT: begin
                    r_rdata <= r_err ? 64'd0 : mem_rdata_i;
                    r_state <= RD_RESP;
                end
                RD_RESP: begin
                    if (axi_req_i.r_ready) begin
                        if (w_last_beat) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 9'd1;
                            r_addr  <= w_addr_nxt;
                            r_state <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (axi_req_i.w_valid) begin
                        if (r_cnt != 9'h1FF) r_cnt <= r_cnt + 9'd1;
                        r_addr <= w_addr_nxt;
                        // A committed exclusive beat has passed the check; a plain beat only clears on a hit.
                        if (!w_suppress && (r_lock || w_res_hit)) r_res_vld <= 1'b0;
                        if (axi_req_i.w.last) begin
                            r_bad_last <= !w_last_beat;
                            r_state    <= WR_RESP;
                        end
                    end
                end
                WR_RESP: if (axi_req_i.b_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_resp_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        unique case (r_state)
            IDLE: begin
                axi_resp_o.ar_ready = w_sel_rd;
                axi_resp_o.aw_ready = w_sel_wr;
            end
            RD_REQ: begin
                mem_req_o  = !r_err;
                mem_addr_o = r_addr;
            end
            RD_RESP: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.data  = r_rdata;
                axi_resp_o.r.id    = r_id;
                axi_resp_o.r.last  = w_last_beat;
                axi_resp_o.r.resp  = r_err ? RESP_SLVERR : (r_lock ? RESP_EXOKAY : RESP_OKAY);
            end
            WR_DATA: begin
                axi_resp_o.w_ready = 1'b1;
                mem_req_o   = axi_req_i.w_valid;
                mem_we_o    = axi_req_i.w_valid;
                mem_addr_o  = r_addr;
                mem_wdata_o = axi_req_i.w.data;
                mem_be_o    = (axi_req_i.w_valid && !w_suppress) ? axi_req_i.w.strb : 8'h00;
            end
            WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = r_id;
                axi_resp_o.b.resp  = (r_err || r_bad_last) ? RESP_SLVERR
                                   : ((r_lock && r_excl_ok) ? RESP_EXOKAY : RESP_OKAY);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: transaction table plus hand-written arbitration and backpressure sequences.
module tb_axi_mem_responder;
    import ariane_axi::*;

    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] EX = 2'b01;
    localparam logic [1:0] SE = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    req_t        req;
    resp_t       resp;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    axi_mem_responder #(.AxiNumWords(4), .AxiIdWidth(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_be_o   (mem_be),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: one-cycle read latency, byte-enabled writes, loaded while mem_init is high.
    logic [63:0] mem [0:8191];
    logic        mem_init = 1'b1;
    int          req_cnt  = 0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 64'd0;
            mem[13'h200] <= 64'hDEADBEEF_CAFEF00D;
            mem[13'h600] <= 64'h01234567_89ABCDEF;
        end else if (mem_req && mem_we) begin
            for (int j = 0; j < 8; j++)
                if (mem_be[j]) mem[mem_addr[15:3]][j*8 +: 8] <= mem_wdata[j*8 +: 8];
        end
        if (mem_req && !mem_we) mem_rdata <= mem[mem_addr[15:3]];
        if (mem_req) req_cnt <= req_cnt + 1;
    end

    typedef struct packed {
        logic             wr;
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [3:0]       id;
        logic             lock;
        logic [5:0]       atop;
        int               nb;
        logic [1:0]       resp;
        logic [7:0][63:0] dat;
        logic [7:0][7:0]  strb;
        logic [7:0][7:0]  be;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [63:0] addr, logic [7:0] len, logic [2:0] size,
                                logic [3:0] id, logic lock, logic [5:0] atop, int nb, logic [1:0] rsp,
                                logic [63:0] d0, logic [7:0] s0, logic [7:0] b0);
        vec_t v;
        v = '0;
        v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.id = id;
        v.lock = lock; v.atop = atop; v.nb = nb; v.resp = rsp;
        v.dat[0] = d0; v.strb[0] = s0; v.be[0] = b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_read(input vec_t v, input int k);
        int lat;
        int req0;
        @(posedge clk); #1;
        req.ar = '0;
        req.ar.addr = v.addr; req.ar.len = v.len; req.ar.size = v.size;
        req.ar.id = v.id; req.ar.lock = v.lock; req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!resp.ar_ready && lat < 20) begin @(negedge clk); lat++; end
        chk($sformatf("v%0d_ar_hs", k), 64'(lat < 20), 64'd1);
        req0 = req_cnt;
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        for (int b = 0; b < v.nb; b++) begin
            lat = 0;
            do begin @(negedge clk); lat++; end while (!resp.r_valid && lat < 20);
            chk($sformatf("v%0d_r%0d_lat", k, b), 64'(lat), 64'd3);
            chk($sformatf("v%0d_r%0d_data", k, b), resp.r.data, v.dat[b[2:0]]);
            chk($sformatf("v%0d_r%0d_last", k, b), 64'(resp.r.last), 64'(b == v.nb - 1));
            chk($sformatf("v%0d_r%0d_id", k, b), 64'(resp.r.id), 64'(v.id));
            chk($sformatf("v%0d_r%0d_resp", k, b), 64'(resp.r.resp), 64'(v.resp));
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
        chk($sformatf("v%0d_mem_reqs", k), 64'(req_cnt - req0), 64'((v.resp == SE) ? 0 : v.nb));
    endtask

    task automatic do_write(input vec_t v, input int k);
        int lat;
        @(posedge clk); #1;
        req.aw = '0;
        req.aw.addr = v.addr; req.aw.len = v.len; req.aw.size = v.size; req.aw.id = v.id;
        req.aw.lock = v.lock; req.aw.atop = v.atop; req.aw.burst = 2'b01;
        req.aw_valid = 1'b1;
        req.w.data = v.dat[0]; req.w.strb = v.strb[0]; req.w.last = (v.nb == 1);
        req.w_valid = 1'b1;
        lat = 0;
        @(negedge clk);
        chk($sformatf("v%0d_w_early_rdy", k), 64'(resp.w_ready), 64'd0);
        while (!resp.aw_ready && lat < 20) begin @(negedge clk); lat++; end
        chk($sformatf("v%0d_aw_hs", k), 64'(lat < 20), 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            req.w.data = v.dat[b[2:0]]; req.w.strb = v.strb[b[2:0]]; req.w.last = (b == v.nb - 1);
            req.w_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_w%0d_rdy", k, b), 64'(resp.w_ready), 64'd1);
            chk($sformatf("v%0d_w%0d_req", k, b), 64'(mem_req && mem_we), 64'd1);
            chk($sformatf("v%0d_w%0d_addr", k, b), mem_addr, v.addr + (64'(b) << v.size));
            chk($sformatf("v%0d_w%0d_be", k, b), 64'(mem_be), 64'(v.be[b[2:0]]));
            @(posedge clk); #1;
        end
        req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_b_vld", k), 64'(resp.b_valid), 64'd1);
        chk($sformatf("v%0d_b_id", k), 64'(resp.b.id), 64'(v.id));
        chk($sformatf("v%0d_b_resp", k), 64'(resp.b.resp), 64'(v.resp));
        @(posedge clk); #1;
        req.b_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v [17];
        int   lat;
        int   req0;

        req = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
        chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
        chk("rst_w_ready", 64'(resp.w_ready), 64'd0);
        chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
        chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
        chk("rst_mem_req", 64'({mem_req, mem_we, mem_be}), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);

        v[0]  = mk(1'b0, 64'h1000, 8'd0, 3'd3, 4'd2, 1'b0, 6'h00, 1, OK, 64'hDEADBEEF_CAFEF00D, 8'h00, 8'h00);
        v[1]  = mk(1'b1, 64'h2000, 8'd3, 3'd3, 4'd3, 1'b0, 6'h00, 4, OK, 64'h11111111_11111111, 8'hFF, 8'hFF);
        v[1].dat[1] = 64'h22222222_22222222; v[1].strb[1] = 8'h0F; v[1].be[1] = 8'h0F;
        v[1].dat[2] = 64'h33333333_33333333; v[1].strb[2] = 8'hF0; v[1].be[2] = 8'hF0;
        v[1].dat[3] = 64'h44444444_44444444; v[1].strb[3] = 8'hFF; v[1].be[3] = 8'hFF;
        v[2]  = mk(1'b0, 64'h2000, 8'd3, 3'd3, 4'd3, 1'b0, 6'h00, 4, OK, 64'h11111111_11111111, 8'h00, 8'h00);
        v[2].dat[1] = 64'h00000000_22222222;
        v[2].dat[2] = 64'h33333333_00000000;
        v[2].dat[3] = 64'h44444444_44444444;
        v[3]  = mk(1'b0, 64'h3000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, EX, 64'h01234567_89ABCDEF, 8'h00, 8'h00);
        v[4]  = mk(1'b1, 64'h3000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, EX, 64'h55555555_55555555, 8'hFF, 8'hFF);
        v[5]  = mk(1'b1, 64'h3000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, OK, 64'h66666666_66666666, 8'hFF, 8'h00);
        v[6]  = mk(1'b0, 64'h3000, 8'd0, 3'd3, 4'd2, 1'b0, 6'h00, 1, OK, 64'h55555555_55555555, 8'h00, 8'h00);
        v[7]  = mk(1'b0, 64'h3000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, EX, 64'h55555555_55555555, 8'h00, 8'h00);
        v[8]  = mk(1'b1, 64'h3004, 8'd0, 3'd2, 4'd4, 1'b0, 6'h00, 1, OK, 64'h77777777_88888888, 8'hF0, 8'hF0);
        v[9]  = mk(1'b1, 64'h3000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, OK, 64'h99999999_99999999, 8'hFF, 8'h00);
        v[10] = mk(1'b0, 64'h3000, 8'd0, 3'd3, 4'd2, 1'b0, 6'h00, 1, OK, 64'h77777777_55555555, 8'h00, 8'h00);
        v[11] = mk(1'b0, 64'h1000, 8'd4, 3'd3, 4'd2, 1'b0, 6'h00, 5, SE, 64'd0, 8'h00, 8'h00);
        v[12] = mk(1'b1, 64'h2000, 8'd0, 3'd3, 4'd3, 1'b0, 6'h20, 1, SE, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 8'h00);
        v[13] = mk(1'b1, 64'h2000, 8'd3, 3'd3, 4'd3, 1'b0, 6'h00, 2, SE, 64'hABABABAB_ABABABAB, 8'hFF, 8'hFF);
        v[13].dat[1] = 64'hABABABAB_ABABABAB; v[13].strb[1] = 8'hFF; v[13].be[1] = 8'hFF;
        v[14] = mk(1'b0, 64'h1000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, EX, 64'hDEADBEEF_CAFEF00D, 8'h00, 8'h00);
        v[15] = mk(1'b1, 64'h1000, 8'd0, 3'd3, 4'd2, 1'b1, 6'h00, 1, OK, 64'h12121212_12121212, 8'hFF, 8'h00);
        v[16] = mk(1'b1, 64'h1000, 8'd0, 3'd3, 4'd1, 1'b1, 6'h00, 1, EX, 64'h34343434_34343434, 8'hFF, 8'hFF);

        for (int k = 0; k < 17; k++) begin
            if (v[k].wr) do_write(v[k], k);
            else         do_read(v[k], k);
        end

        // Read response held off for 5 cycles.
        @(posedge clk); #1;
        req.ar = '0; req.ar.addr = 64'h2018; req.ar.size = 3'd3; req.ar.id = 4'd6; req.ar_valid = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!resp.ar_ready && lat < 20) begin @(negedge clk); lat++; end
        chk("bp_ar_hs", 64'(lat < 20), 64'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!resp.r_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("bp_r_seen", 64'(lat < 20), 64'd1);
        req0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_r_vld%0d", i), 64'(resp.r_valid), 64'd1);
            chk($sformatf("bp_r_data%0d", i), resp.r.data, 64'h44444444_44444444);
            chk($sformatf("bp_r_id%0d", i), 64'(resp.r.id), 64'd6);
            chk($sformatf("bp_r_noreq%0d", i), 64'(req_cnt - req0), 64'd0);
            @(negedge clk);
        end
        req.r_ready = 1'b1;
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        @(negedge clk);
        chk("bp_r_drop", 64'(resp.r_valid), 64'd0);

        // Write response held off for 5 cycles.
        @(posedge clk); #1;
        req.aw = '0; req.aw.addr = 64'h2018; req.aw.size = 3'd3; req.aw.id = 4'd7; req.aw_valid = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!resp.aw_ready && lat < 20) begin @(negedge clk); lat++; end
        chk("bp_aw_hs", 64'(lat < 20), 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        req.w.data = 64'h5A5A5A5A_5A5A5A5A; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
        @(negedge clk);
        chk("bp_w_rdy", 64'(resp.w_ready), 64'd1);
        @(posedge clk); #1;
        req.w_valid = 1'b0;
        req0 = req_cnt;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_b_vld%0d", i), 64'(resp.b_valid), 64'd1);
            chk($sformatf("bp_b_id%0d", i), 64'(resp.b.id), 64'd7);
            chk($sformatf("bp_b_resp%0d", i), 64'(resp.b.resp), 64'(OK));
            chk($sformatf("bp_b_wrdy%0d", i), 64'(resp.w_ready), 64'd0);
            chk($sformatf("bp_b_noreq%0d", i), 64'(req_cnt - req0), 64'd0);
            @(negedge clk);
        end
        req.b_ready = 1'b1;
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        @(negedge clk);
        chk("bp_b_drop", 64'(resp.b_valid), 64'd0);

        // Simultaneous AR/AW straight after a fresh reset: read first, then alternate.
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req.ar.addr = 64'h1000; req.ar.size = 3'd3; req.ar.id = 4'd4; req.ar_valid = 1'b1;
        req.aw.addr = 64'h2010; req.aw.size = 3'd3; req.aw.id = 4'd5; req.aw_valid = 1'b1;
        @(negedge clk);
        chk("sim1_ar_ready", 64'(resp.ar_ready), 64'd1);
        chk("sim1_aw_ready", 64'(resp.aw_ready), 64'd0);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        @(negedge clk);
        chk("sim1_aw_held", 64'(resp.aw_ready), 64'd0);
        lat = 1;
        while (!resp.r_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("sim1_r_lat", 64'(lat), 64'd3);
        chk("sim1_r_data", resp.r.data, 64'h34343434_34343434);
        @(posedge clk); #1;
        req.r_ready  = 1'b0;
        req.ar_valid = 1'b1;
        @(negedge clk);
        chk("sim2_aw_ready", 64'(resp.aw_ready), 64'd1);
        chk("sim2_ar_ready", 64'(resp.ar_ready), 64'd0);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        req.w.data = 64'hC3C3C3C3_C3C3C3C3; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
        @(negedge clk);
        chk("sim2_w_rdy", 64'(resp.w_ready), 64'd1);
        chk("sim2_w_addr", mem_addr, 64'h2010);
        @(posedge clk); #1;
        req.w_valid  = 1'b0;
        req.b_ready  = 1'b1;
        req.aw_valid = 1'b1;
        @(negedge clk);
        chk("sim2_b_vld", 64'(resp.b_valid), 64'd1);
        chk("sim2_b_id", 64'(resp.b.id), 64'd5);
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        @(negedge clk);
        chk("sim3_ar_ready", 64'(resp.ar_ready), 64'd1);
        chk("sim3_aw_ready", 64'(resp.aw_ready), 64'd0);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.r_ready  = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!resp.r_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("sim3_r_seen", 64'(lat < 20), 64'd1);
        chk("sim3_r_data", resp.r.data, 64'h34343434_34343434);
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 subordinate that terminates the core's `ariane_axi` request/response bus and drives a single-ported, fixed-latency 64-bit memory, for example a boot RAM or a test memory behind the cache subsystems. It accepts one transaction at a time, either read or write, and supports INCR bursts of up to `AxiNumWords` beats. It also implements a single-entry exclusive monitor, so LR/SC sequences issued by the core's AXI initiators complete with correct EXOKAY/OKAY semantics.

## Interface
- `AxiNumWords`, default 4: maximum burst length in beats; `len >= AxiNumWords` gets SLVERR.
- `AxiIdWidth`, default 4: width of the AXI ID.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `axi_req_i` in `ariane_axi::req_t`: AW/W/AR channels plus `b_ready`/`r_ready`.
- `axi_resp_o` out `ariane_axi::resp_t`: ready signals plus the B/R channels.
- `mem_req_o` out 1: memory access strobe, one per beat.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out 64: byte address of the beat; the memory ignores `[2:0]`.
- `mem_wdata_o` out 64: write data, equal to `w.data`.
- `mem_be_o` out 8: byte enables, equal to `w.strb`, or 0 when the write is suppressed.
- `mem_rdata_i` in 64: read data, valid exactly one cycle after `mem_req_o && !mem_we_o`.

## Operation
- State machine states: `IDLE`, `RD_REQ`, `RD_WAIT`, `RD_RESP`, `WR_DATA`, `WR_RESP`.

**Arbitration (`IDLE` only)**
- `ar_ready`/`aw_ready` are asserted combinationally for the selected channel only.
- If only one of `ar_valid`/`aw_valid` is high, that channel is selected.
- If both are high, the channel not served last is selected; the served-last flag resets to "write", so read wins first.
- On handshake, latch `addr`, `len`, `size`, `id`, `lock`, `atop`, clear the beat counter `cnt`, and compute `err`.
- `err` = (`len >= AxiNumWords`) || (`size > 3`) || (write with `atop != 0`).

**Read**
- `RD_REQ`: `mem_req_o=1`, `mem_we_o=0`, `mem_addr_o=addr_q`, then go to `RD_WAIT`.
- `RD_WAIT`: register `mem_rdata_i` into `rdata_q`, then go to `RD_RESP`.
- `RD_RESP`:
  - Drive `r_valid=1`, `r.data=rdata_q`, `r.id=id_q`, `r.last=(cnt==len_q)`.
  - `r.resp` = SLVERR if `err`, EXOKAY if `lock_q`, else OKAY.
  - On `r_ready`: if last, go to `IDLE`; else `cnt++`, `addr_q += 1<<size_q` (64-bit wrap), go to `RD_REQ`.
- When `err` is set, `RD_REQ` still sequences the beats but does not assert `mem_req_o`, and `r.data` is 0.
- An exclusive read (`lock_q`) sets the reservation `{valid, addr_q[63:3], id_q}` at the AR handshake, overwriting any previous reservation.

**Write**
- `WR_DATA`:
  - `w_ready=1`.
  - Each `w_valid` beat issues `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o=addr_q`.
  - `mem_be_o` is forced to 0 when the beat is suppressed; `mem_req_o` is still issued.
  - After each beat: `cnt++`, `addr_q` increments.
  - The beat with `w.last` moves to `WR_RESP`.
- A beat is suppressed if any of: `err`; `cnt > len_q`; exclusive write with a failed reservation check.
- Reservation check (exclusive write):
  - Pass = valid && `addr[63:3]` matches && `id` matches.
  - Evaluated at the AW handshake; applies to the whole burst.
- If `w.last` does not coincide with `cnt==len_q`, the response is SLVERR.
- `WR_RESP`:
  - `b_valid=1`, `b.id=id_q`.
  - `b.resp` priority: SLVERR > EXOKAY (exclusive passed) > OKAY.
  - On `b_ready`, go to `IDLE`.

**Reservation clear**
- A passing exclusive write clears the reservation.
- Any non-suppressed non-exclusive write beat whose `addr[63:3]` matches the reservation clears it.
- An exclusive write that fails leaves the reservation unchanged.

## Timing
- Reset: state `IDLE`, all `*_ready`/`*_valid` 0, `mem_req_o=0`, `mem_we_o=0`, `mem_be_o=0`, data and address outputs 0, reservation invalid, served-last = write.
- Reset asserted mid-burst aborts the transaction with no response; it is the initiator's responsibility to reset too.
- Read latency: AR handshake at cycle T, `mem_req_o` at T+1, `r_valid` at T+3.
- Read throughput: 3 cycles per beat when `r_ready` is held high.
- Write timing: AW handshake at T, first `w_ready` at T+1, one beat per cycle. `b_valid` rises the cycle after the last beat.
- `r_valid`/`b_valid` stay high with stable payload until the handshake.
- `w_ready` is never asserted outside `WR_DATA`; `ar_ready`/`aw_ready` never outside `IDLE`. W beats arriving early are held off.

## Test plan
- **Single read.** Memory word 0x1000 = 0xDEADBEEF_CAFEF00D; AR addr=0x1000, len=0, size=3, id=2, `r_ready=1`. Expect `r_valid` at T+3, data matches, `last=1`, `id=2`, OKAY.
- **4-beat write then read-back.** AW 0x2000 len=3 with strb 0xFF/0x0F/0xF0/0xFF. Expect `mem_addr_o` = 0x2000, 0x2008, 0x2010, 0x2018, `mem_be_o` equal to the strobes, B OKAY. Read-back returns the merged bytes with `last` only on beat 3.
- **Exclusive pair.**
  - Locked AR 0x3000 id=1 returns EXOKAY.
  - Locked AW 0x3000 id=1 writes and returns EXOKAY.
  - A second locked AW 0x3000 returns OKAY with `mem_be_o=0` (reservation already cleared).
  - A plain write to 0x3004 between a new locked AR and its locked AW makes that AW fail with OKAY.
- **Simultaneous AR and AW in IDLE after reset.** Read is served first and the write is held (`aw_ready=0`). The next simultaneous pair serves the write first.
- **Errors.**
  - `len=4` with `AxiNumWords=4`: SLVERR on all 5 R beats, no `mem_req_o`.
  - `atop=6'h20`: 1 W beat consumed, `mem_be_o=0`, B SLVERR.
  - `w.last` on beat 1 of a len=3 burst: B SLVERR.
- **Backpressure.** `r_ready`/`b_ready` held low for 5 cycles. Expect valid and payload stable throughout, and no further `mem_req_o`.
